// File: rtl/timer_irq_ctrl.sv
// CPU register slave for the millisecond timer: divider/compare programming, counter snapshots,
// pending/missed irq capture, one-shot deadline alarm and a soft-reset pulse. Reads complete 1 cycle after accept.
module timer_irq_ctrl #(
  parameter logic [31:0] DEFAULT_DIV = 32'd74249,
  parameter int          RESET_PULSE = 4
) (
  input  logic        clk_sys,
  input  logic        millisecond_counter_reset,
  input  logic        cpu_valid,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic [31:0] millisecond_counter,
  input  logic [31:0] millisecond_real,
  input  logic        interupt_output,
  output logic [31:0] sysclk_frequency,
  output logic [31:0] interupt_counter,
  output logic        timer_reset_req,
  output logic        cpu_irq
);

  localparam logic [7:0] PULSE_LEN = 8'(RESET_PULSE);

  logic        irq_en;
  logic        deadline_en;
  logic        pending;
  logic        deadline_hit;
  logic [7:0]  missed;
  logic        prev;
  logic [31:0] deadline;
  logic [7:0]  pulse_cnt;

  logic        accept;
  logic        wr;
  logic        irq_edge;
  logic        w1c_pending;
  logic        w1c_hit;
  logic        deadline_wr;
  logic        soft_reset;
  logic        hit_set;
  logic [31:0] diff;
  logic [31:0] rd_mux;

  assign accept      = cpu_valid & ~cpu_ready;
  assign wr          = accept & cpu_we;
  assign irq_edge    = interupt_output & ~prev;
  assign w1c_pending = wr && cpu_addr == 3'd1 && cpu_wdata[0];
  assign w1c_hit     = wr && cpu_addr == 3'd1 && cpu_wdata[2];
  assign deadline_wr = wr && cpu_addr == 3'd6;
  assign soft_reset  = wr && cpu_addr == 3'd0 && cpu_wdata[2];
  // Signed-distance compare keeps the alarm correct across counter wrap.
  assign diff        = millisecond_counter - deadline;
  assign hit_set     = deadline_en & ~deadline_hit & ~diff[31];

  always_comb begin
    rd_mux = 32'd0;
    case (cpu_addr)
      3'd0: rd_mux = {30'd0, deadline_en, irq_en};
      3'd1: rd_mux = {16'd0, missed, 5'd0, deadline_hit, interupt_output, pending};
      3'd2: rd_mux = sysclk_frequency;
      3'd3: rd_mux = interupt_counter;
      3'd4: rd_mux = millisecond_counter;
      3'd5: rd_mux = millisecond_real;
      3'd6: rd_mux = deadline;
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_sys or posedge millisecond_counter_reset) begin
    if (millisecond_counter_reset) begin
      cpu_ready        <= 1'b0;
      cpu_rdata        <= 32'd0;
      irq_en           <= 1'b0;
      deadline_en      <= 1'b0;
      pending          <= 1'b0;
      deadline_hit     <= 1'b0;
      missed           <= 8'd0;
      prev             <= 1'b0;
      deadline         <= 32'd0;
      pulse_cnt        <= 8'd0;
      sysclk_frequency <= DEFAULT_DIV;
      interupt_counter <= 32'd0;
      timer_reset_req  <= 1'b0;
      cpu_irq          <= 1'b0;
    end else begin
      cpu_ready <= accept;
      cpu_rdata <= (accept && !cpu_we) ? rd_mux : 32'd0;
      prev      <= interupt_output;

      if (wr && cpu_addr == 3'd0) begin
        irq_en      <= cpu_wdata[0];
        deadline_en <= cpu_wdata[1];
      end
      if (wr && cpu_addr == 3'd2) sysclk_frequency <= cpu_wdata;
      if (wr && cpu_addr == 3'd3) interupt_counter <= cpu_wdata;
      if (deadline_wr) deadline <= millisecond_counter + cpu_wdata;

      // A new edge beats a coincident W1C; the W1C still clears the missed count.
      if (irq_edge) begin
        pending <= 1'b1;
        if (w1c_pending)
          missed <= 8'd0;
        else if (pending && missed != 8'hFF)
          missed <= missed + 8'd1;
      end else if (w1c_pending) begin
        pending <= 1'b0;
        missed  <= 8'd0;
      end

      if (deadline_wr)
        deadline_hit <= 1'b0;
      else if (hit_set)
        deadline_hit <= 1'b1;
      else if (w1c_hit)
        deadline_hit <= 1'b0;

      if (soft_reset) begin
        pulse_cnt       <= PULSE_LEN;
        timer_reset_req <= 1'b1;
      end else if (pulse_cnt != 8'd0) begin
        pulse_cnt       <= pulse_cnt - 8'd1;
        timer_reset_req <= pulse_cnt > 8'd1;
      end

      cpu_irq <= irq_en & (pending | (deadline_en & deadline_hit));
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Self-checking bench for timer_irq_ctrl: vector table for register access plus
// hand-written sequences for irq capture, deadline wrap, soft-reset pulse and async reset.
module tb_timer_irq_ctrl;

  logic        clk_sys = 1'b0;
  logic        millisecond_counter_reset;
  logic        cpu_valid;
  logic        cpu_we;
  logic [2:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [31:0] millisecond_counter;
  logic [31:0] millisecond_real;
  logic        interupt_output;
  logic [31:0] sysclk_frequency;
  logic [31:0] interupt_counter;
  logic        timer_reset_req;
  logic        cpu_irq;

  timer_irq_ctrl dut (
    .clk_sys                   (clk_sys),
    .millisecond_counter_reset (millisecond_counter_reset),
    .cpu_valid                 (cpu_valid),
    .cpu_we                    (cpu_we),
    .cpu_addr                  (cpu_addr),
    .cpu_wdata                 (cpu_wdata),
    .cpu_rdata                 (cpu_rdata),
    .cpu_ready                 (cpu_ready),
    .millisecond_counter       (millisecond_counter),
    .millisecond_real          (millisecond_real),
    .interupt_output           (interupt_output),
    .sysclk_frequency          (sysclk_frequency),
    .interupt_counter          (interupt_counter),
    .timer_reset_req           (timer_reset_req),
    .cpu_irq                   (cpu_irq)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where cpu_ready is seen.
  task automatic xfer(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp, input string name);
    int n;
    cpu_valid = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    if (!we) exp_q.push_back(exp);
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!cpu_ready && n < 20);
    if (!cpu_ready) begin
      checks++;
      errors++;
      $display("FAIL %s: no cpu_ready within 20 cycles", name);
      if (!we) void'(exp_q.pop_front());
    end else if (!we) begin
      check(name, cpu_rdata, exp_q.pop_front());
    end
    cpu_valid = 1'b0;
    cpu_we    = 1'b0;
  endtask

  task automatic toggle_irq(input int times);
    for (int i = 0; i < times; i++) begin
      interupt_output = 1'b0;
      @(negedge clk_sys);
      interupt_output = 1'b1;
      @(negedge clk_sys);
    end
  endtask

  vec_t rst_vecs[8];
  vec_t vecs[8];

  initial begin
    int pulse_hi;

    for (int i = 0; i < 8; i++) begin
      rst_vecs[i].we    = 1'b0;
      rst_vecs[i].addr  = 3'(i);
      rst_vecs[i].wdata = 32'd0;
      rst_vecs[i].exp   = (i == 2) ? 32'd74249 : 32'd0;
    end
    vecs[0] = '{1'b1, 3'd3, 32'd5,         32'd0};
    vecs[1] = '{1'b0, 3'd3, 32'd0,         32'd5};
    vecs[2] = '{1'b1, 3'd2, 32'h0000ABCD,  32'd0};
    vecs[3] = '{1'b0, 3'd2, 32'd0,         32'h0000ABCD};
    vecs[4] = '{1'b0, 3'd4, 32'd0,         32'h11223344};
    vecs[5] = '{1'b0, 3'd5, 32'd0,         32'h55667788};
    vecs[6] = '{1'b1, 3'd7, 32'hFFFFFFFF,  32'd0};
    vecs[7] = '{1'b0, 3'd7, 32'd0,         32'd0};

    millisecond_counter_reset = 1'b1;
    cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = 3'd0; cpu_wdata = 32'd0;
    millisecond_counter = 32'd0; millisecond_real = 32'd0; interupt_output = 1'b0;
    repeat (3) @(negedge clk_sys);
    millisecond_counter_reset = 1'b0;
    @(negedge clk_sys);

    check("rst_sysclk_frequency", sysclk_frequency, 32'd74249);
    check("rst_interupt_counter", interupt_counter, 32'd0);
    check("rst_cpu_irq", {31'd0, cpu_irq}, 32'd0);
    check("rst_timer_reset_req", {31'd0, timer_reset_req}, 32'd0);
    for (int i = 0; i < 8; i++)
      xfer(rst_vecs[i].we, rst_vecs[i].addr, rst_vecs[i].wdata, rst_vecs[i].exp, $sformatf("rst_read_%0d", i));

    millisecond_counter = 32'h11223344;
    millisecond_real    = 32'h55667788;
    for (int i = 0; i < 8; i++)
      xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec_%0d", i));
    check("interupt_counter_out", interupt_counter, 32'd5);
    check("sysclk_frequency_out", sysclk_frequency, 32'h0000ABCD);
    @(negedge clk_sys);
    check("rdata_idle_zero", cpu_rdata, 32'd0);

    // Rising edge -> pending -> cpu_irq one cycle later; W1C drops it.
    xfer(1'b1, 3'd0, 32'd1, 32'd0, "wr_ctrl_irq_en");
    repeat (5) @(negedge clk_sys);
    interupt_output = 1'b1;
    @(negedge clk_sys);
    check("irq_not_yet", {31'd0, cpu_irq}, 32'd0);
    @(negedge clk_sys);
    check("irq_raised", {31'd0, cpu_irq}, 32'd1);
    xfer(1'b0, 3'd1, 32'd0, 32'h00000003, "status_pending");
    xfer(1'b1, 3'd1, 32'd1, 32'd0, "w1c_pending");
    check("irq_still_high", {31'd0, cpu_irq}, 32'd1);
    @(negedge clk_sys);
    check("irq_cleared", {31'd0, cpu_irq}, 32'd0);

    // Missed-edge counting and saturation.
    toggle_irq(1);
    toggle_irq(3);
    xfer(1'b0, 3'd1, 32'd0, 32'h00000303, "missed_3");
    toggle_irq(300);
    xfer(1'b0, 3'd1, 32'd0, 32'h0000FF03, "missed_sat");
    interupt_output = 1'b0;
    @(negedge clk_sys);
    interupt_output = 1'b1;
    xfer(1'b1, 3'd1, 32'd1, 32'd0, "w1c_vs_edge");
    xfer(1'b0, 3'd1, 32'd0, 32'h00000003, "set_wins_missed_clr");

    // Deadline across counter wrap.
    xfer(1'b1, 3'd1, 32'd1, 32'd0, "w1c_pending_2");
    millisecond_counter = 32'hFFFFFFF0;
    xfer(1'b1, 3'd0, 32'd3, 32'd0, "wr_ctrl_dl_en");
    xfer(1'b1, 3'd6, 32'h20, 32'd0, "wr_deadline");
    xfer(1'b0, 3'd6, 32'd0, 32'h00000010, "rd_deadline");
    millisecond_counter = 32'hFFFFFFFF;
    repeat (2) @(negedge clk_sys);
    check("dl_irq_ffffffff", {31'd0, cpu_irq}, 32'd0);
    xfer(1'b0, 3'd1, 32'd0, 32'h00000002, "dl_nohit_ffffffff");
    millisecond_counter = 32'h0000000F;
    repeat (2) @(negedge clk_sys);
    check("dl_irq_0f", {31'd0, cpu_irq}, 32'd0);
    xfer(1'b0, 3'd1, 32'd0, 32'h00000002, "dl_nohit_0f");
    millisecond_counter = 32'h00000010;
    repeat (2) @(negedge clk_sys);
    check("dl_irq_10", {31'd0, cpu_irq}, 32'd1);
    xfer(1'b0, 3'd1, 32'd0, 32'h00000006, "dl_hit_10");

    // Soft-reset pulse length, single and re-triggered.
    pulse_hi = 0;
    fork
      repeat (14) begin
        @(negedge clk_sys);
        if (timer_reset_req) pulse_hi++;
      end
      xfer(1'b1, 3'd0, 32'h4, 32'd0, "soft_rst_1");
    join
    check("pulse_single", 32'(pulse_hi), 32'd4);
    pulse_hi = 0;
    fork
      repeat (16) begin
        @(negedge clk_sys);
        if (timer_reset_req) pulse_hi++;
      end
      begin
        xfer(1'b1, 3'd0, 32'h4, 32'd0, "soft_rst_2a");
        xfer(1'b1, 3'd0, 32'h4, 32'd0, "soft_rst_2b");
      end
    join
    check("pulse_retrigger", 32'(pulse_hi), 32'd6);
    xfer(1'b0, 3'd2, 32'd0, 32'h0000ABCD, "div_after_soft_rst");

    // Async reset aborts an accepted read; the held request completes after release.
    interupt_output = 1'b0;
    @(negedge clk_sys);
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd2;
    exp_q.push_back(32'd74249);
    @(posedge clk_sys);
    #1 millisecond_counter_reset = 1'b1;
    #1 check("abort_ready", {31'd0, cpu_ready}, 32'd0);
    repeat (2) @(negedge clk_sys);
    check("abort_ready_held", {31'd0, cpu_ready}, 32'd0);
    check("abort_sysclk", sysclk_frequency, 32'd74249);
    check("abort_compare", interupt_counter, 32'd0);
    check("abort_irq", {31'd0, cpu_irq}, 32'd0);
    millisecond_counter_reset = 1'b0;
    @(negedge clk_sys);
    check("reissue_ready", {31'd0, cpu_ready}, 32'd1);
    check("reissue_rdata", cpu_rdata, exp_q.pop_front());
    cpu_valid = 1'b0;
    @(negedge clk_sys);
    xfer(1'b0, 3'd0, 32'd0, 32'd0, "ctrl_after_reset");
    xfer(1'b0, 3'd3, 32'd0, 32'd0, "compare_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
